// File: rtl/jk_flip_flop_bank.sv
// Bank of WIDTH positive-edge JK flip-flops sharing one mode selector.
// Modes: per-bit JK, per-bit toggle, parallel load, and an up/down counter
// whose JK inputs are generated internally. Adds an enable, a synchronous
// reset, a terminal-count flag and a one-cycle change strobe.
module jk_flip_flop_bank #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               WRAP      = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TC,
  output logic             CHG
);

  localparam logic [1:0] ModeJk  = 2'b00;
  localparam logic [1:0] ModeT   = 2'b01;
  localparam logic [1:0] ModeD   = 2'b10;
  localparam logic [1:0] ModeCnt = 2'b11;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             chg_q;
  logic [WIDTH-1:0] cnt_toggle;
  logic             at_term;

  // Counter toggle mask: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic low_ones;
    logic low_zeros;
    low_ones   = 1'b1;
    low_zeros  = 1'b1;
    cnt_toggle = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_toggle[i] = DIR ? low_ones : low_zeros;
      low_ones      = low_ones & q_q[i];
      low_zeros     = low_zeros & ~q_q[i];
    end
    at_term = DIR ? (&q_q) : ~(|q_q);
  end

  // Next-state selection per mode.
  always_comb begin
    q_d = q_q;
    unique case (MODE)
      ModeJk:  q_d = (J & ~q_q) | (~K & q_q);  // characteristic JK equation
      ModeT:   q_d = q_q ^ J;
      ModeD:   q_d = J;
      ModeCnt: begin
        if (at_term && !WRAP) q_d = q_q;  // saturate at terminal
        else                  q_d = q_q ^ cnt_toggle;
      end
      default: q_d = q_q;
    endcase
  end

  // State register: reset overrides everything; enable gates updates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= RESET_VAL;
      chg_q <= 1'b0;
    end else if (EN) begin
      q_q   <= q_d;
      chg_q <= (q_d != q_q);
    end else begin
      chg_q <= 1'b0;
    end
  end

  // Outputs; TC deliberately ignores RST.
  always_comb begin
    Q   = q_q;
    QN  = ~q_q;
    CHG = chg_q;
    TC  = (MODE == ModeCnt) && EN && at_term;
  end

endmodule
